lcd_msg_arbiter: RTL and testbench

- Shares the 16-character line 2 of the LCD display controller between two requesters: R0, the keypad/plaintext echo, and R1, the LEA ciphertext/result.
- A requester wins a grant, streams 16 bytes, and the block commits them atomically to a 128-bit line buffer. That buffer drives the display controller's 16 line-2 character inputs.
- Each committed message is held for a minimum time so it survives at least one full LCD refresh loop before it can be replaced.

---
 rtl/lcd_msg_arbiter_if.sv | 15 +
 rtl/lcd_msg_arbiter.sv | 150 +++++++++++++++
 tb/tb_lcd_msg_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_msg_arbiter_if.sv
// rtl/lcd_msg_arbiter_if.sv - requester-side handshake bundle for lcd_msg_arbiter
`timescale 1ns/1ps
interface lcd_msg_arbiter_if;
  logic       REQ0;
  logic       VALID0;
  logic [7:0] DATA0;
  logic       REQ1;
  logic       VALID1;
  logic [7:0] DATA1;
  logic       GNT0;
  logic       GNT1;

  modport master (output REQ0, VALID0, DATA0, REQ1, VALID1, DATA1, input GNT0, GNT1);
  modport slave  (input REQ0, VALID0, DATA0, REQ1, VALID1, DATA1, output GNT0, GNT1);
endinterface

// File: rtl/lcd_msg_arbiter.sv
// rtl/lcd_msg_arbiter.sv - two-requester arbiter committing 16-byte messages to LCD line 2
// Optional load stall timeout enabled by defining LCD_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module lcd_msg_arbiter #(
`ifdef LCD_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  parameter int HOLD_CYCLES = 1100,
  parameter int HOLD_W      = 11
) (
  input  logic             CLK,
  input  logic             RESETN,
  lcd_msg_arbiter_if.slave bus,
  output logic [127:0]     LINE2,
  output logic             OWNER,
  output logic             NEW_MSG,
  output logic             ABORT
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} stateT;

  stateT             state, stateNext;
  logic              owner, ownerNext;
  logic              lastGrant, lastGrantNext;
  logic [3:0]        idx, idxNext;
  logic [HOLD_W-1:0] holdCnt, holdNext;
  logic [127:0]      staging;
  logic              commitPending, commitNext;
  logic              abortNext;
  logic              accept;
  logic              reqOwn, validOwn;
  logic [7:0]        dataOwn;
`ifdef LCD_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stallCnt, stallNext;
`endif

  assign reqOwn   = owner ? bus.REQ1   : bus.REQ0;
  assign validOwn = owner ? bus.VALID1 : bus.VALID0;
  assign dataOwn  = owner ? bus.DATA1  : bus.DATA0;

  // Grants come only from registered state, never from REQ/VALID.
  assign bus.GNT0 = (state == LOAD) && !owner;
  assign bus.GNT1 = (state == LOAD) && owner;

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    idxNext       = idx;
    holdNext      = holdCnt;
    commitNext    = 1'b0;
    abortNext     = 1'b0;
    accept        = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
    stallNext     = stallCnt;
`endif
    case (state)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          // On a tie the requester not granted last time wins.
          ownerNext     = (bus.REQ0 && bus.REQ1) ? !lastGrant : bus.REQ1;
          lastGrantNext = ownerNext;
          idxNext       = '0;
          stateNext     = LOAD;
`ifdef LCD_ARB_TIMEOUT_EN
          stallNext     = '0;
`endif
        end
      end
      LOAD: begin
        if (!reqOwn) begin
          abortNext = 1'b1;
          idxNext   = '0;
          stateNext = IDLE;
        end else if (validOwn) begin
          accept  = 1'b1;
          idxNext = idx + 4'd1;
`ifdef LCD_ARB_TIMEOUT_EN
          stallNext = '0;
`endif
          if (idx == 4'd15) begin
            commitNext = 1'b1;
            idxNext    = '0;
            holdNext   = '0;
            stateNext  = HOLD;
          end
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (stallCnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          abortNext = 1'b1;
          idxNext   = '0;
          stateNext = IDLE;
        end else begin
          stallNext = stallCnt + STALL_W'(1);
        end
`endif
      end
      HOLD: begin
        if (holdCnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          holdNext  = '0;
          stateNext = IDLE;
        end else begin
          holdNext = holdCnt + HOLD_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state         <= IDLE;
      owner         <= 1'b0;
      lastGrant     <= 1'b1;
      idx           <= '0;
      holdCnt       <= '0;
      staging       <= {16{8'h20}};
      commitPending <= 1'b0;
      LINE2         <= {16{8'h20}};
      OWNER         <= 1'b0;
      NEW_MSG       <= 1'b0;
      ABORT         <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      stallCnt      <= '0;
`endif
    end else begin
      state         <= stateNext;
      owner         <= ownerNext;
      lastGrant     <= lastGrantNext;
      idx           <= idxNext;
      holdCnt       <= holdNext;
      commitPending <= commitNext;
      NEW_MSG       <= commitPending;
      ABORT         <= abortNext;
`ifdef LCD_ARB_TIMEOUT_EN
      stallCnt      <= stallNext;
`endif
      if (accept) begin
        staging[{idx, 3'b000} +: 8] <= dataOwn;
      end
      // Whole line swaps in one edge so the display never shows a mix.
      if (commitPending) begin
        LINE2 <= staging;
        OWNER <= owner;
      end
    end
  end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// tb/tb_lcd_msg_arbiter.sv - directed self-checking bench for lcd_msg_arbiter
`timescale 1ns/1ps
module tb_lcd_msg_arbiter;
  logic         CLK = 1'b0;
  logic         RESETN;
  logic [127:0] LINE2;
  logic         OWNER;
  logic         NEW_MSG;
  logic         ABORT;

  lcd_msg_arbiter_if bus();

  lcd_msg_arbiter dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .bus     (bus),
    .LINE2   (LINE2),
    .OWNER   (OWNER),
    .NEW_MSG (NEW_MSG),
    .ABORT   (ABORT)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef struct {
    logic       req0;
    logic       valid0;
    logic [7:0] data0;
    logic       expGnt0;
    logic       expNew;
  } vecT;

  vecT   vecs[19];
  int    passCnt = 0;
  int    totalCnt = 0;
  int    cyc = 0;
  int    lastNewCyc = 0;
  int    newCnt = 0;
  int    abortCnt = 0;
  int    gnt0Cnt = 0;
  int    gnt1Cnt = 0;
  string msgA = "PLAINTEXT 000001";
  string msgB = "CIPHER ABCD1234 ";

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
    if (NEW_MSG) begin
      newCnt++;
      lastNewCyc = cyc;
    end
    if (ABORT) abortCnt++;
    if (bus.GNT0) gnt0Cnt++;
    if (bus.GNT1) gnt1Cnt++;
  endtask

  function automatic logic [127:0] toLine(input string s);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = s[k];
    return l;
  endfunction

  task automatic drive(input int who, input logic req, input logic valid, input logic [7:0] data);
    if (who == 0) begin
      bus.REQ0 = req; bus.VALID0 = valid; bus.DATA0 = data;
    end else begin
      bus.REQ1 = req; bus.VALID1 = valid; bus.DATA1 = data;
    end
  endtask

  task automatic doReset;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    RESETN = 1'b1;
    tick;
    tick;
    RESETN = 1'b0;
    tick;
  endtask

  task automatic stream(input int who, input string s, input int n);
    for (int i = 0; i < n; i++) begin
      drive(who, 1'b1, 1'b1, s[i]);
      tick;
    end
    drive(who, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic waitGnt(input int who, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if ((who == 0) ? bus.GNT0 : bus.GNT1) begin
        at = cyc;
        return;
      end
      tick;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, at, g0, g1, n0, ab;

    // Reset state, then 50 idle cycles
    doReset;
    check("rst line2", LINE2, BLANK);
    check("rst owner", OWNER, 1'b0);
    check("rst gnt0", bus.GNT0, 1'b0);
    check("rst gnt1", bus.GNT1, 1'b0);
    check("rst newmsg", NEW_MSG, 1'b0);
    check("rst abort", ABORT, 1'b0);
    n0 = newCnt; g0 = gnt0Cnt; g1 = gnt1Cnt;
    repeat (50) tick;
    check("idle newmsg count", newCnt - n0, 0);
    check("idle grant count", (gnt0Cnt - g0) + (gnt1Cnt - g1), 0);
    check("idle line2", LINE2, BLANK);

    // Table-driven R0 transfer with VALID0 held high
    vecs[0] = '{1'b1, 1'b1, 8'h3F, 1'b1, 1'b0};
    for (int i = 1; i <= 16; i++) vecs[i] = '{1'b1, 1'b1, msgA[i-1], logic'(i < 16), 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    n0 = newCnt; g0 = gnt0Cnt;
    for (int i = 0; i < 19; i++) begin
      drive(0, vecs[i].req0, vecs[i].valid0, vecs[i].data0);
      tick;
      check($sformatf("A%0d gnt0", i), bus.GNT0, vecs[i].expGnt0);
      check($sformatf("A%0d gnt1", i), bus.GNT1, 1'b0);
      check($sformatf("A%0d newmsg", i), NEW_MSG, vecs[i].expNew);
    end
    check("A gnt0 cycles", gnt0Cnt - g0, 16);
    check("A newmsg count", newCnt - n0, 1);
    check("A first char", LINE2[7:0], 8'h50);
    check("A last char", LINE2[127:120], 8'h31);
    check("A line2", LINE2, toLine(msgA));
    check("A owner", OWNER, 1'b0);

    // Simultaneous requests: R0 first, R1 after hold while REQ0 stays high
    doReset;
    drive(0, 1'b1, 1'b0, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h00);
    tick;
    check("B gnt0 first", bus.GNT0, 1'b1);
    check("B gnt1 first", bus.GNT1, 1'b0);
    stream(0, msgA, 16);
    tick;
    check("B newmsg R0", NEW_MSG, 1'b1);
    t0 = lastNewCyc;
    g0 = gnt0Cnt;
    waitGnt(1, 1200, at);
    check("B gnt1 delay", at - t0, 1100);
    check("B gnt0 during hold", gnt0Cnt - g0, 0);
    stream(1, msgB, 16);
    tick;
    check("B newmsg R1", NEW_MSG, 1'b1);
    check("B newmsg gap", lastNewCyc - t0, 1117);
    check("B owner", OWNER, 1'b1);
    check("B line2", LINE2, toLine(msgB));
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);

    // Late R1 waits out hold, then aborts after 7 bytes; drop beats a valid byte
    doReset;
    drive(0, 1'b1, 1'b0, 8'h00);
    waitGnt(0, 5, at);
    check("C gnt0 latency", at >= 0, 1'b1);
    stream(0, msgA, 16);
    drive(0, 1'b0, 1'b0, 8'h00);
    tick;
    t0 = lastNewCyc;
    repeat (10) tick;
    drive(1, 1'b1, 1'b0, 8'h00);
    waitGnt(1, 1200, at);
    check("C gnt1 after hold", at - t0, 1100);
    stream(1, msgB, 7);
    ab = abortCnt;
    drive(1, 1'b0, 1'b1, 8'h5A);
    drive(0, 1'b1, 1'b0, 8'h00);
    tick;
    check("C abort pulse", ABORT, 1'b1);
    check("C gnt1 dropped", bus.GNT1, 1'b0);
    check("C gnt0 not yet", bus.GNT0, 1'b0);
    check("C line2 kept", LINE2, toLine(msgA));
    check("C owner kept", OWNER, 1'b0);
    check("C no newmsg", NEW_MSG, 1'b0);
    drive(1, 1'b0, 1'b0, 8'h00);
    tick;
    check("C gnt0 next", bus.GNT0, 1'b1);
    check("C abort single", abortCnt - ab, 1);
    drive(0, 1'b0, 1'b0, 8'h00);
    tick;
    tick;

`ifdef LCD_ARB_TIMEOUT_EN
    // Stall timeout after 3 bytes; pending R1 takes over
    doReset;
    drive(0, 1'b1, 1'b0, 8'h00);
    tick;
    stream(0, msgA, 3);
    drive(1, 1'b1, 1'b0, 8'h00);
    at = -1;
    for (int n = 1; n <= 200; n++) begin
      tick;
      if (ABORT) begin
        at = n;
        break;
      end
    end
    check("D timeout cycles", at, 64);
    check("D line2 kept", LINE2, BLANK);
    check("D gnt1 pre", bus.GNT1, 1'b0);
    tick;
    check("D gnt1 next", bus.GNT1, 1'b1);
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    tick;
    tick;
`endif

    // Asynchronous reset in the middle of a load
    doReset;
    drive(0, 1'b1, 1'b0, 8'h00);
    tick;
    stream(0, msgB, 2);
    RESETN = 1'b1;
    #1;
    check("R gnt0 cleared", bus.GNT0, 1'b0);
    check("R line2 blank", LINE2, BLANK);
    drive(0, 1'b0, 1'b0, 8'h00);
    tick;
    RESETN = 1'b0;
    tick;
    check("R gnt0 after", bus.GNT0, 1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
